// File: rtl/spi_fpga_master_burst.sv
// SPI master with runtime mode/bit-order/divider, one-hot active-low chip selects
// and multi-word bursts that keep CS asserted between words.
module spi_fpga_master_burst #(
  parameter int unsigned PACK_LENGTH  = 8,
  parameter int unsigned NUM_CS       = 4,
  parameter int unsigned CS_INDEX_W   = $clog2(NUM_CS > 1 ? NUM_CS : 2),
  parameter int unsigned DIV_W        = 8,
  parameter bit          DEFAULT_CPOL = 1'b0
) (
  input  logic                   IN_CLOCK,
  input  logic                   IN_RESET,
  input  logic [PACK_LENGTH-1:0] IN_TX_DATA,
  input  logic                   IN_TX_VALID,
  input  logic                   IN_TX_LAST,
  input  logic [1:0]             IN_MODE,
  input  logic                   IN_LSB_FIRST,
  input  logic [DIV_W-1:0]       IN_CLK_DIV,
  input  logic [CS_INDEX_W-1:0]  IN_CS_SELECT,
  output logic                   OUT_TX_READY,
  input  logic                   MISO,
  output logic                   MOSI,
  output logic [NUM_CS-1:0]      CS,
  output logic                   SCLK,
  output logic [PACK_LENGTH-1:0] OUT_RX_DATA,
  output logic                   OUT_RX_VALID,
  output logic                   OUT_BUSY,
  output logic                   OUT_ACTION_DONE
);

  localparam int unsigned EDGE_W = $clog2(2 * PACK_LENGTH + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * PACK_LENGTH);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SETUP, S_SHIFT, S_NEXT, S_DONE
  } state_t;

  state_t r_state, w_state_next;

  logic [DIV_W-1:0]       r_cnt, r_div;
  logic [EDGE_W-1:0]      r_edges;
  logic                   r_cpha, r_lsb, r_last;
  logic [CS_INDEX_W-1:0]  r_cs_sel;
  logic [PACK_LENGTH-1:0] r_tx, r_rx, r_rx_data;
  logic                   r_rx_valid, r_done, r_sclk, r_mosi;
  logic [NUM_CS-1:0]      r_cs;

  logic                   w_ready, w_busy, w_accept, w_cnt_zero, w_word_end, w_edge;
  logic [EDGE_W-1:0]      w_edge_num;
  logic                   w_leading, w_setup_entry, w_drive, w_sample, w_tx_bit;
  logic                   w_state_change, w_active_next;
  logic [PACK_LENGTH-1:0] w_tx_cur, w_tx_shifted;
  logic [NUM_CS-1:0]      w_cs_sel_n;

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_state_next = S_PRE;
      S_PRE:   if (w_cnt_zero) w_state_next = S_SETUP;
      S_SETUP: if (w_cnt_zero) w_state_next = S_SHIFT;
      S_SHIFT: if (w_word_end) w_state_next = r_last ? S_DONE : S_NEXT;
      S_NEXT:  if (w_accept)   w_state_next = S_SETUP;
      S_DONE:  if (w_cnt_zero) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_ready = ~IN_RESET;
        w_busy  = 1'b0;
      end
      S_NEXT:  w_ready = ~IN_RESET;
      default: ;
    endcase
  end

  assign w_accept       = IN_TX_VALID & w_ready;
  assign w_cnt_zero     = (r_cnt == '0);
  assign w_state_change = (w_state_next != r_state);
  assign w_word_end     = (r_state == S_SHIFT) && w_cnt_zero && (r_edges == LAST_EDGE);
  // The first SCLK edge fires as SETUP expires, so edge k lands k*H clocks after CS falls.
  assign w_edge         = w_cnt_zero &&
                          ((r_state == S_SETUP) || ((r_state == S_SHIFT) && (r_edges != LAST_EDGE)));
  assign w_edge_num     = (r_state == S_SETUP) ? EDGE_W'(1) : r_edges + EDGE_W'(1);
  assign w_leading      = w_edge_num[0];
  assign w_setup_entry  = (w_state_next == S_SETUP) && (r_state != S_SETUP);
  assign w_drive        = r_cpha ? (w_edge && w_leading)
                                 : (w_setup_entry || (w_edge && !w_leading && (w_edge_num != LAST_EDGE)));
  assign w_sample       = w_edge && (w_leading != r_cpha);
  // A word accepted in NEXT is driven straight from the input on the same edge it is latched.
  assign w_tx_cur       = (r_state == S_NEXT) ? IN_TX_DATA : r_tx;
  assign w_tx_bit       = r_lsb ? w_tx_cur[0] : w_tx_cur[PACK_LENGTH-1];
  assign w_tx_shifted   = r_lsb ? (w_tx_cur >> 1) : (w_tx_cur << 1);
  assign w_active_next  = (w_state_next == S_SETUP) || (w_state_next == S_SHIFT) ||
                          (w_state_next == S_NEXT);

  always_comb begin
    w_cs_sel_n = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (r_cs_sel == CS_INDEX_W'(i)) w_cs_sel_n[i] = 1'b0;
    end
  end

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      r_cnt      <= '0;
      r_div      <= '0;
      r_edges    <= '0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_last     <= 1'b0;
      r_cs_sel   <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      r_sclk     <= DEFAULT_CPOL;
      r_mosi     <= 1'b0;
      r_cs       <= '1;
    end else begin
      r_rx_valid <= w_word_end;
      r_done     <= w_word_end && r_last;
      r_cs       <= w_active_next ? w_cs_sel_n : '1;

      if (w_state_change || w_edge) r_cnt <= (r_state == S_IDLE) ? IN_CLK_DIV : r_div;
      else if (!w_cnt_zero)         r_cnt <= r_cnt - DIV_W'(1);

      if (w_edge) begin
        r_sclk  <= ~r_sclk;
        r_edges <= w_edge_num;
      end

      if (w_accept) begin
        r_tx   <= IN_TX_DATA;
        r_last <= IN_TX_LAST;
      end

      if (w_accept && (r_state == S_IDLE)) begin
        r_cpha   <= IN_MODE[0];
        r_lsb    <= IN_LSB_FIRST;
        r_div    <= IN_CLK_DIV;
        r_cs_sel <= IN_CS_SELECT;
        r_sclk   <= IN_MODE[1];
      end

      if (w_drive) begin
        r_mosi <= w_tx_bit;
        r_tx   <= w_tx_shifted;
      end

      if (w_sample) r_rx <= r_lsb ? {MISO, r_rx[PACK_LENGTH-1:1]} : {r_rx[PACK_LENGTH-2:0], MISO};

      if (w_word_end) r_rx_data <= r_rx;
    end
  end

  assign OUT_TX_READY    = w_ready;
  assign OUT_BUSY        = w_busy;
  assign OUT_RX_DATA     = r_rx_data;
  assign OUT_RX_VALID    = r_rx_valid;
  assign OUT_ACTION_DONE = r_done;
  assign MOSI            = r_mosi;
  assign SCLK            = r_sclk;
  assign CS              = r_cs;

endmodule

// File: tb/tb_spi_fpga_master_burst.sv
// Bench for spi_fpga_master_burst: a behavioural SPI slave plus a pin monitor
// produce the expected words, pulse counts and timing for randomized bursts.
module tb_spi_fpga_master_burst;

  localparam int unsigned NCS = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last, lsb_first, miso, mosi, sclk, tx_ready;
  logic [1:0] mode;
  logic [7:0] clk_div;
  logic [2:0] cs_select;
  logic [NCS-1:0] cs;
  logic [7:0] rx_data;
  logic       rx_valid, busy, done;

  always #5 clk = ~clk;

  spi_fpga_master_burst #(
    .PACK_LENGTH(8), .NUM_CS(NCS), .DIV_W(8), .DEFAULT_CPOL(1'b0)
  ) dut (
    .IN_CLOCK(clk), .IN_RESET(rst), .IN_TX_DATA(tx_data), .IN_TX_VALID(tx_valid),
    .IN_TX_LAST(tx_last), .IN_MODE(mode), .IN_LSB_FIRST(lsb_first), .IN_CLK_DIV(clk_div),
    .IN_CS_SELECT(cs_select), .OUT_TX_READY(tx_ready), .MISO(miso), .MOSI(mosi), .CS(cs),
    .SCLK(sclk), .OUT_RX_DATA(rx_data), .OUT_RX_VALID(rx_valid), .OUT_BUSY(busy),
    .OUT_ACTION_DONE(done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Transfer configuration shared with the slave/monitor
  logic [1:0] cur_mode = 2'b00;
  logic       cur_lsb  = 1'b0;
  int         cur_h    = 1;
  int         cur_sel  = 0;
  logic [7:0] tx_w [8];
  logic [7:0] sv_w [8];

  // Monitor-owned running totals
  logic [7:0] rx_log  [256];
  logic [7:0] cap_log [256];
  int rx_cnt = 0, dn_cnt = 0, cs_low_cyc = 0, cs_rise = 0, gap_bad = 0, bad_cs = 0;
  int next_bad = 0, cs_gap_bad = 0, togs = 0, cap_total = 0;

  // Slave: counts SCLK edges while selected, shifts out sv_w and captures MOSI.
  initial begin
    logic prev_sclk, cs_prev_low;
    int slv_cnt, cyc, tog_in_word, last_tog, cs_high_run, g, wi, bi;
    logic [NCS-1:0] exp_cs;
    prev_sclk = 1'b0; cs_prev_low = 1'b0; slv_cnt = 0; cyc = 0;
    tog_in_word = 0; last_tog = 0; cs_high_run = 1000;
    miso = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      exp_cs = '1;
      if (cur_sel < NCS) exp_cs[cur_sel] = 1'b0;
      if (cs !== '1 && cs !== exp_cs) bad_cs++;
      if (tx_ready === 1'b1 && busy === 1'b1 && sclk !== cur_mode[1]) next_bad++;
      if (cs !== '1) begin
        if (!cs_prev_low && cs_high_run < cur_h) cs_gap_bad++;
        cs_high_run = 0;
        cs_low_cyc++;
        if (sclk !== prev_sclk) begin
          togs++;
          if (tog_in_word > 0 && (cyc - last_tog) != cur_h) gap_bad++;
          tog_in_word++;
          last_tog = cyc;
          slv_cnt++;
          if ((slv_cnt % 2 == 1) == (cur_mode[0] == 1'b0)) begin
            wi = (cap_total / 8) % 256;
            bi = cap_total % 8;
            if (bi == 0) cap_log[wi] = 8'h00;
            cap_log[wi][cur_lsb ? bi : 7 - bi] = mosi;
            cap_total++;
          end
        end
        if (cur_mode[0] == 1'b0) g = slv_cnt / 2;
        else                     g = (slv_cnt == 0) ? 0 : (slv_cnt - 1) / 2;
        wi = (g / 8) % 8;
        bi = g % 8;
        miso = cur_lsb ? sv_w[wi][bi] : sv_w[wi][7 - bi];
      end else begin
        if (cs_prev_low) cs_rise++;
        cs_high_run++;
        slv_cnt = 0;
        tog_in_word = 0;
        cap_total = ((cap_total + 7) / 8) * 8;
        miso = 1'b0;
      end
      cs_prev_low = (cs !== '1);
      prev_sclk = sclk;
      if (rx_valid === 1'b1) begin
        rx_log[rx_cnt % 256] = rx_data;
        rx_cnt++;
        tog_in_word = 0;
      end
      if (done === 1'b1) dn_cnt++;
    end
  end

  task automatic fill_random();
    for (int i = 0; i < 8; i++) begin
      tx_w[i] = 8'($urandom);
      sv_w[i] = 8'($urandom);
    end
  endtask

  task automatic run_burst(input string tag, input int n, input logic [1:0] m, input logic lsb,
                           input logic [7:0] div, input logic [2:0] sel, input int gap);
    int rx0, dn0, csl0, rise0, gb0, bc0, nb0, cg0, cap0, h;
    bit ok, acc, in_range;
    h = int'(div) + 1;
    in_range = (int'(sel) < NCS);
    cur_mode = m; cur_lsb = lsb; cur_h = h; cur_sel = int'(sel);
    rx0 = rx_cnt; dn0 = dn_cnt; csl0 = cs_low_cyc; rise0 = cs_rise; gb0 = gap_bad;
    bc0 = bad_cs; nb0 = next_bad; cg0 = cs_gap_bad; cap0 = cap_total / 8;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        ok = 1'b0;
        for (int t = 0; t < 20 * h + 50; t++) begin
          if (tx_ready) begin ok = 1'b1; break; end
          @(posedge clk); #1;
        end
        check({tag, "_ready_wait"}, 32'(ok), 32'd1);
        repeat (gap) begin @(posedge clk); #1; end
      end
      tx_data = tx_w[k];
      tx_valid = 1'b1;
      tx_last = (k == n - 1);
      if (k == 0) begin
        mode = m; lsb_first = lsb; clk_div = div; cs_select = sel;
      end else begin
        mode = 2'($urandom); lsb_first = 1'($urandom); clk_div = 8'($urandom); cs_select = 3'($urandom);
      end
      ok = 1'b0;
      for (int t = 0; t < 20 * h + 50; t++) begin
        acc = tx_ready;
        @(posedge clk); #1;
        if (acc) begin ok = 1'b1; break; end
      end
      check({tag, "_accept"}, 32'(ok), 32'd1);
      tx_valid = 1'b0;
      tx_data = 8'($urandom);
    end
    ok = 1'b0;
    for (int t = 0; t < 20 * h + 50; t++) begin
      if (dn_cnt != dn0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check({tag, "_done_wait"}, 32'(ok), 32'd1);
    ok = 1'b0;
    for (int t = 0; t < 2 * h + 10; t++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check({tag, "_busy_clear"}, 32'(ok), 32'd1);
    check({tag, "_rx_pulses"}, 32'(rx_cnt - rx0), 32'(n));
    check({tag, "_done_pulses"}, 32'(dn_cnt - dn0), 32'd1);
    check({tag, "_cs_releases"}, 32'(cs_rise - rise0), in_range ? 32'd1 : 32'd0);
    for (int k = 0; k < n; k++) begin
      check({tag, "_rx_word"}, 32'(rx_log[(rx0 + k) % 256]), in_range ? 32'(sv_w[k]) : 32'd0);
      if (in_range) check({tag, "_mosi_word"}, 32'(cap_log[(cap0 + k) % 256]), 32'(tx_w[k]));
    end
    if (n == 1) check({tag, "_cs_low_cycles"}, 32'(cs_low_cyc - csl0), in_range ? 32'(17 * h) : 32'd0);
    check({tag, "_half_period"}, 32'(gap_bad - gb0), 32'd0);
    check({tag, "_cs_pattern"}, 32'(bad_cs - bc0), 32'd0);
    check({tag, "_next_sclk"}, 32'(next_bad - nb0), 32'd0);
    check({tag, "_cs_gap"}, 32'(cs_gap_bad - cg0), 32'd0);
    check({tag, "_sclk_idle"}, 32'(sclk), 32'(m[1]));
  endtask

  initial begin
    int rx0, dn0, t0;
    bit ok;
    rst = 1'b1; tx_data = '0; tx_valid = 1'b0; tx_last = 1'b0; mode = '0;
    lsb_first = 1'b0; clk_div = '0; cs_select = '0;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready_low", 32'(tx_ready), 32'd0);
    check("reset_cs", 32'(cs), 32'h1F);
    check("reset_sclk", 32'(sclk), 32'd0);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_pulses", 32'({rx_valid, done, busy}), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(tx_ready), 32'd1);

    fill_random();
    tx_w[0] = 8'hEA; sv_w[0] = 8'h53;
    run_burst("mode2_EA", 1, 2'b10, 1'b0, 8'd1, 3'd0, 0);

    for (int m = 0; m < 4; m++) begin
      fill_random();
      tx_w[0] = 8'hA5; sv_w[0] = 8'h3C;
      run_burst($sformatf("lsb_mode%0d", m), 1, 2'(m), 1'b1, 8'd2, 3'd1, 0);
    end

    fill_random();
    tx_w[0] = 8'h01; tx_w[1] = 8'h02; tx_w[2] = 8'h03;
    run_burst("burst3", 3, 2'b01, 1'b0, 8'd1, 3'd2, 5);

    // Reset part-way through a word
    cur_mode = 2'b00; cur_lsb = 1'b0; cur_h = 2; cur_sel = 0;
    rx0 = rx_cnt; dn0 = dn_cnt; t0 = togs;
    tx_data = 8'h96; tx_valid = 1'b1; tx_last = 1'b1; mode = 2'b00;
    lsb_first = 1'b0; clk_div = 8'd1; cs_select = 3'd0;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (togs - t0 >= 3) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("mid_reset_edges_wait", 32'(ok), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_cs", 32'(cs), 32'h1F);
    check("mid_reset_sclk", 32'(sclk), 32'd0);
    check("mid_reset_mosi", 32'(mosi), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("mid_reset_no_rx", 32'(rx_cnt - rx0), 32'd0);
    check("mid_reset_no_done", 32'(dn_cnt - dn0), 32'd0);
    check("mid_reset_ready", 32'(tx_ready), 32'd1);

    fill_random();
    run_burst("sel3", 1, 2'b00, 1'b0, 8'd1, 3'd3, 0);
    fill_random();
    run_burst("sel2", 1, 2'b11, 1'b1, 8'd1, 3'd2, 0);
    fill_random();
    run_burst("sel5_out_of_range", 1, 2'b01, 1'b0, 8'd1, 3'd5, 0);
    fill_random();
    run_burst("div0", 1, 2'b00, 1'b0, 8'd0, 3'd4, 0);
    fill_random();
    run_burst("div255", 1, 2'b11, 1'b0, 8'd255, 3'd0, 0);

    for (int r = 0; r < 10; r++) begin
      fill_random();
      run_burst($sformatf("rand%0d", r), int'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)), 3'($urandom_range(0, 5)),
                int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
